// File: rtl/lsu_split_access.sv
// Sequential load/store unit: one request per handshake, aligned bus beats, sign/zero-extended response.
// Optional macro LSU_MISALIGN_SPLIT_EN builds the two-beat path for misaligned accesses; otherwise they error.
module lsu_split_access #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_err_i
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LO  = 3'd1,
    WAIT_LO = 3'd2,
`ifdef LSU_MISALIGN_SPLIT_EN
    REQ_HI  = 3'd3,
    WAIT_HI = 3'd4,
`endif
    RESP    = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              signed_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [DATA_W-1:0] lo_q;
  logic              misaligned_q;
  logic [DATA_W-1:0] hi_rdata;
`endif

  logic [OFF_W-1:0]  off;
  logic [ADDR_W-1:0] aligned_addr;
  logic [NB-1:0]     size_mask;
  logic [DATA_W-1:0] lo_rdata;
  logic              req_illegal;
  logic              req_bad;

  function automatic logic is_misaligned(input logic [OFF_W-1:0] o, input logic [1:0] sz);
    return (int'(o) + (1 << sz)) > NB;
  endfunction

  function automatic logic [NB-1:0] byte_mask(input logic [1:0] sz);
    logic [NB-1:0] m;
    case (sz)
      2'd0:    m = NB'(1);
      2'd1:    m = NB'(3);
      2'd2:    m = NB'(15);
      default: m = '1;
    endcase
    return m;
  endfunction

  // Keep the low `bytes` bytes and fill the rest with zeros or the top kept bit.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                               input logic [1:0] sz,
                                               input logic sgn);
    logic [DATA_W-1:0] keep;
    logic              sb;
    case (sz)
      2'd0: begin keep = {DATA_W{1'b1}} >> (DATA_W - 8);  sb = v[7];  end
      2'd1: begin keep = {DATA_W{1'b1}} >> (DATA_W - 16); sb = v[15]; end
      2'd2: begin keep = {DATA_W{1'b1}} >> (DATA_W - 32); sb = v[31]; end
      default: begin keep = '1; sb = v[DATA_W-1]; end
    endcase
    return (sgn && sb) ? (v | ~keep) : (v & keep);
  endfunction

  assign off          = addr_q[OFF_W-1:0];
  assign aligned_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign size_mask    = byte_mask(size_q);
  assign lo_rdata     = mem_rdata_i >> (8 * int'(off));
  assign req_illegal  = (req_size_i == 2'd3) && (DATA_W == 32);

`ifdef LSU_MISALIGN_SPLIT_EN
  assign req_bad      = req_illegal;
  assign misaligned_q = is_misaligned(off, size_q);
  assign hi_rdata     = mem_rdata_i << (8 * (NB - int'(off)));
`else
  assign req_bad      = req_illegal || is_misaligned(req_addr_i[OFF_W-1:0], req_size_i);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = req_bad ? RESP : REQ_LO;
        end
      end
      REQ_LO: begin
        if (mem_gnt_i) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (mem_rvalid_i) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          state_d = (!mem_err_i && misaligned_q) ? REQ_HI : RESP;
`else
          state_d = RESP;
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      REQ_HI: begin
        if (mem_gnt_i) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (mem_rvalid_i) state_d = RESP;
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus request fields decode only registered state, so they hold while waiting for a grant.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    case (state_q)
      REQ_LO: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = aligned_addr;
        mem_be_o    = size_mask << off;
        mem_wdata_o = wdata_q << (8 * int'(off));
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      REQ_HI: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = aligned_addr + ADDR_W'(NB);
        mem_be_o    = size_mask >> (NB - int'(off));
        mem_wdata_o = wdata_q >> (8 * (NB - int'(off)));
      end
`endif
      default: ;
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign rsp_rdata_o = rsp_rdata_q;

  // rsp_rdata_q only changes when a response is being prepared, so it holds between responses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q      <= '0;
      size_q      <= '0;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      lo_q        <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q   <= req_addr_i;
            size_q   <= req_size_i;
            we_q     <= req_we_i;
            signed_q <= req_signed_i;
            wdata_q  <= req_wdata_i;
            err_q    <= req_bad;
            if (req_bad) rsp_rdata_q <= '0;
          end
        end
        WAIT_LO: begin
          if (mem_rvalid_i) begin
            if (mem_err_i) begin
              err_q       <= 1'b1;
              rsp_rdata_q <= '0;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            else if (misaligned_q) begin
              lo_q <= lo_rdata;
            end
`endif
            else begin
              err_q       <= 1'b0;
              rsp_rdata_q <= we_q ? '0 : extend(lo_rdata, size_q, signed_q);
            end
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        WAIT_HI: begin
          if (mem_rvalid_i) begin
            err_q       <= mem_err_i;
            rsp_rdata_q <= (mem_err_i || we_q) ? '0
                           : extend(lo_q | hi_rdata, size_q, signed_q);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_split_access.sv
// Directed bench for lsu_split_access (DATA_W = 32); expectations follow LSU_MISALIGN_SPLIT_EN when defined.
module tb_lsu_split_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int tests_run = 0;
  int tests_failed = 0;

  // Observations collected by run_access for the calling test
  int          nbeats, rsp_count, rsp_cycle;
  logic [31:0] b_addr[4];
  logic [31:0] b_wdata[4];
  logic [3:0]  b_be[4];
  logic        b_we[4];
  logic        stable_ok;
  logic [31:0] rsp_data;
  logic        rsp_e;
  logic        post_rst_req, post_rst_ready;

  always #5 clk = ~clk;

  lsu_split_access #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err)
  );

  // Issues one request (cycle 1 = acceptance cycle) and plays the memory side.
  task automatic run_access(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rd_lo, input logic [31:0] rd_hi,
                            input logic err_lo, input int gnt_delay, input int rst_beat);
    int cyc, wait_cnt, granted, stop_at, rst_cycle;
    logic pend;
    nbeats = 0; rsp_count = 0; rsp_cycle = 0; stable_ok = 1'b1;
    rsp_data = 32'hx; rsp_e = 1'bx; post_rst_req = 1'bx; post_rst_ready = 1'bx;
    wait_cnt = 0; granted = 0; stop_at = 40; rst_cycle = 0; pend = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    while (cyc < stop_at) begin
      @(posedge clk); #1;
      cyc++;
      req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
      if (rst_cycle > 0 && cyc == rst_cycle + 1) begin
        rst = 1'b1;
        post_rst_req = mem_req;
        post_rst_ready = req_ready;
      end
      if (pend) begin
        pend = 1'b0;
        if (granted == rst_beat) begin
          rst = 1'b0;
          rst_cycle = cyc;
          stop_at = cyc + 5;
        end else begin
          mem_rvalid = 1'b1;
          mem_rdata = (granted == 1) ? rd_lo : rd_hi;
          mem_err = (granted == 1) && err_lo;
        end
      end
      if (mem_req) begin
        if (wait_cnt == 0) begin
          if (nbeats < 4) begin
            b_addr[nbeats] = mem_addr; b_be[nbeats] = mem_be;
            b_wdata[nbeats] = mem_wdata; b_we[nbeats] = mem_we;
          end
          nbeats++;
        end else if (nbeats <= 4) begin
          if (mem_addr !== b_addr[nbeats-1] || mem_be !== b_be[nbeats-1] ||
              mem_wdata !== b_wdata[nbeats-1] || mem_we !== b_we[nbeats-1])
            stable_ok = 1'b0;
        end
        if (wait_cnt >= gnt_delay) begin
          mem_gnt = 1'b1; pend = 1'b1; granted++; wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      if (rsp_valid) begin
        if (rsp_count == 0) begin
          rsp_data = rsp_rdata; rsp_e = rsp_err; rsp_cycle = cyc; stop_at = cyc + 3;
        end
        rsp_count++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 0; req_we = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); end
    tests_run++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rsp: got valid=%b err=%b expected 0/0", rsp_valid, rsp_err); end
    tests_run++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_req: got req=%b we=%b expected 0/0", mem_req, mem_we); end
    tests_run++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_mem_fields: got addr=%h be=%h wdata=%h expected zeros", mem_addr, mem_be, mem_wdata); end
    tests_run++; if (rsp_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h expected 0", rsp_rdata); end
    rst = 1'b1;
  endtask

  task automatic test_aligned_word();
    run_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 0, 0);
    tests_run++; if (nbeats !== 1) begin tests_failed++; $display("[TB] FAIL lw_beats: got %0d expected 1", nbeats); end
    tests_run++; if (b_addr[0] !== 32'h100 || b_be[0] !== 4'b1111 || b_we[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL lw_beat: got addr=%h be=%b we=%b expected 100/1111/0", b_addr[0], b_be[0], b_we[0]); end
    tests_run++; if (rsp_data !== 32'hDEADBEEF || rsp_e !== 1'b0) begin tests_failed++; $display("[TB] FAIL lw_rsp: got %h err=%b expected deadbeef err=0", rsp_data, rsp_e); end
    tests_run++; if (rsp_cycle !== 4 || rsp_count !== 1) begin tests_failed++; $display("[TB] FAIL lw_latency: got cycle %0d pulses %0d expected 4 and 1", rsp_cycle, rsp_count); end
  endtask

  task automatic test_byte_loads();
    run_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF0000, 32'h0, 1'b0, 0, 0);
    tests_run++; if (b_addr[0] !== 32'h100 || b_be[0] !== 4'b1000) begin tests_failed++; $display("[TB] FAIL lb_beat: got addr=%h be=%b expected 100/1000", b_addr[0], b_be[0]); end
    tests_run++; if (rsp_data !== 32'hFFFFFF80 || rsp_e !== 1'b0) begin tests_failed++; $display("[TB] FAIL lb_signed: got %h err=%b expected ffffff80 err=0", rsp_data, rsp_e); end
    run_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF0000, 32'h0, 1'b0, 0, 0);
    tests_run++; if (rsp_data !== 32'h00000080) begin tests_failed++; $display("[TB] FAIL lbu_unsigned: got %h expected 00000080", rsp_data); end
    run_access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h7FFF1234, 32'h0, 1'b0, 0, 0);
    tests_run++; if (b_be[0] !== 4'b1100 || rsp_data !== 32'h00007FFF || rsp_count !== 1) begin tests_failed++; $display("[TB] FAIL lh_top_half: got be=%b data=%h expected 1100 and 00007fff", b_be[0], rsp_data); end
  endtask

  task automatic test_split_load();
    run_access(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h55667788, 32'h11223344, 1'b0, 0, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
    tests_run++; if (nbeats !== 2) begin tests_failed++; $display("[TB] FAIL split_lw_beats: got %0d expected 2", nbeats); end
    tests_run++; if (b_addr[0] !== 32'h100 || b_be[0] !== 4'b1100) begin tests_failed++; $display("[TB] FAIL split_lw_lo: got addr=%h be=%b expected 100/1100", b_addr[0], b_be[0]); end
    tests_run++; if (b_addr[1] !== 32'h104 || b_be[1] !== 4'b0011) begin tests_failed++; $display("[TB] FAIL split_lw_hi: got addr=%h be=%b expected 104/0011", b_addr[1], b_be[1]); end
    tests_run++; if (rsp_data !== 32'h33445566 || rsp_e !== 1'b0 || rsp_cycle !== 6) begin tests_failed++; $display("[TB] FAIL split_lw_rsp: got %h err=%b cycle %0d expected 33445566 err=0 cycle 6", rsp_data, rsp_e, rsp_cycle); end
`else
    tests_run++; if (nbeats !== 0) begin tests_failed++; $display("[TB] FAIL split_lw_nobus: got %0d beats expected 0", nbeats); end
    tests_run++; if (rsp_e !== 1'b1 || rsp_data !== 32'h0 || rsp_count !== 1) begin tests_failed++; $display("[TB] FAIL split_lw_err: got err=%b data=%h pulses %0d expected 1/0/1", rsp_e, rsp_data, rsp_count); end
`endif
  endtask

  task automatic test_lo_error();
    run_access(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h55667788, 32'h11223344, 1'b1, 0, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
    tests_run++; if (nbeats !== 1) begin tests_failed++; $display("[TB] FAIL lo_err_beats: got %0d expected 1", nbeats); end
`else
    tests_run++; if (nbeats !== 0) begin tests_failed++; $display("[TB] FAIL lo_err_beats: got %0d expected 0", nbeats); end
`endif
    tests_run++; if (rsp_e !== 1'b1 || rsp_data !== 32'h0 || rsp_count !== 1) begin tests_failed++; $display("[TB] FAIL lo_err_rsp: got err=%b data=%h pulses %0d expected 1/0/1", rsp_e, rsp_data, rsp_count); end
  endtask

  task automatic test_split_store();
    run_access(1'b1, 2'd1, 1'b0, 32'h103, 32'h0000ABCD, 32'h0, 32'h0, 1'b0, 0, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
    tests_run++; if (nbeats !== 2) begin tests_failed++; $display("[TB] FAIL sh_beats: got %0d expected 2", nbeats); end
    tests_run++; if (b_addr[0] !== 32'h100 || b_be[0] !== 4'b1000 || b_wdata[0] !== 32'hCD000000 || b_we[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL sh_lo: got addr=%h be=%b wdata=%h we=%b expected 100/1000/cd000000/1", b_addr[0], b_be[0], b_wdata[0], b_we[0]); end
    tests_run++; if (b_addr[1] !== 32'h104 || b_be[1] !== 4'b0001 || b_wdata[1] !== 32'h000000AB || b_we[1] !== 1'b1) begin tests_failed++; $display("[TB] FAIL sh_hi: got addr=%h be=%b wdata=%h we=%b expected 104/0001/000000ab/1", b_addr[1], b_be[1], b_wdata[1], b_we[1]); end
    tests_run++; if (rsp_count !== 1 || rsp_data !== 32'h0 || rsp_e !== 1'b0) begin tests_failed++; $display("[TB] FAIL sh_rsp: got pulses %0d data=%h err=%b expected 1/0/0", rsp_count, rsp_data, rsp_e); end
`else
    tests_run++; if (nbeats !== 0 || rsp_e !== 1'b1 || rsp_count !== 1) begin tests_failed++; $display("[TB] FAIL sh_err: got beats %0d err=%b pulses %0d expected 0/1/1", nbeats, rsp_e, rsp_count); end
`endif
  endtask

  task automatic test_illegal_size();
    run_access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h12345678, 32'h0, 1'b0, 0, 0);
    tests_run++; if (nbeats !== 0 || rsp_e !== 1'b1 || rsp_data !== 32'h0 || rsp_cycle !== 2) begin tests_failed++; $display("[TB] FAIL ld_illegal: got beats %0d err=%b data=%h cycle %0d expected 0/1/0/2", nbeats, rsp_e, rsp_data, rsp_cycle); end
  endtask

  task automatic test_backpressure();
    run_access(1'b1, 2'd2, 1'b0, 32'h108, 32'h12345678, 32'h0, 32'h0, 1'b0, 3, 0);
    tests_run++; if (stable_ok !== 1'b1 || nbeats !== 1) begin tests_failed++; $display("[TB] FAIL bp_stable: got stable=%b beats %0d expected 1 and 1", stable_ok, nbeats); end
    tests_run++; if (b_addr[0] !== 32'h108 || b_be[0] !== 4'b1111 || b_wdata[0] !== 32'h12345678) begin tests_failed++; $display("[TB] FAIL bp_beat: got addr=%h be=%b wdata=%h expected 108/1111/12345678", b_addr[0], b_be[0], b_wdata[0]); end
    tests_run++; if (rsp_cycle !== 7 || rsp_data !== 32'h0 || rsp_e !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_rsp: got cycle %0d data=%h err=%b expected 7/0/0", rsp_cycle, rsp_data, rsp_e); end
  endtask

  task automatic test_reset_mid_op();
`ifdef LSU_MISALIGN_SPLIT_EN
    run_access(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h55667788, 32'h11223344, 1'b0, 0, 2);
`else
    run_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h55667788, 32'h0, 1'b0, 0, 1);
`endif
    tests_run++; if (post_rst_req !== 1'b0 || post_rst_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_state: got req=%b ready=%b expected 0/1", post_rst_req, post_rst_ready); end
    tests_run++; if (rsp_count !== 0) begin tests_failed++; $display("[TB] FAIL midrst_no_rsp: got %0d pulses expected 0", rsp_count); end
    tests_run++; if (rsp_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL midrst_rdata: got %h expected 0", rsp_rdata); end
  endtask

  initial begin
    test_reset();
    test_aligned_word();
    test_byte_loads();
    test_split_load();
    test_lo_error();
    test_split_store();
    test_illegal_size();
    test_backpressure();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
